// File: rtl/phase_sequencer_ctrl.sv
// Phase sequencer and control decoder for the 16-bit SIMPLE-style core.
// Optional single-step input enabled by defining SINGLE_STEP_EN.
module phase_sequencer_ctrl #(
    parameter int INSTR_W  = 16,
    parameter int MEM_WAIT = 0,
    parameter int MUX_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               exec,
`ifdef SINGLE_STEP_EN
    input  logic               step,
`endif
    input  logic [INSTR_W-1:0] instr,
    input  logic               flag_s,
    input  logic               flag_z,
    input  logic               flag_c,
    input  logic               flag_v,
    output logic [2:0]         phase,
    output logic               running,
    output logic               halted,
    output logic               ir_e,
    output logic               pc_e,
    output logic               ar_e,
    output logic               br_e,
    output logic               dr_e,
    output logic               mdr_e,
    output logic               flags_e,
    output logic               genr_w,
    output logic               mem_rd,
    output logic               mem_w,
    output logic [3:0]         alu_op,
    output logic [MUX_W-1:0]   m_sel,
    output logic               branch_taken
);

    localparam logic [2:0] P0 = 3'd0;
    localparam logic [2:0] P1 = 3'd1;
    localparam logic [2:0] P2 = 3'd2;
    localparam logic [2:0] P3 = 3'd3;
    localparam logic [2:0] P4 = 3'd4;

    localparam logic [1:0] LP_WAIT = 2'(MEM_WAIT);

    logic [2:0] r_phase;
    logic       r_run;
    logic       r_halt;
    logic       r_stop;
    logic       r_bt;
    logic [1:0] r_wait;

    logic [1:0] w_op;
    logic [2:0] w_sub;
    logic [2:0] w_cnd;
    logic [3:0] w_fn;
    logic       w_ld, w_st, w_li, w_b, w_bc;
    logic       w_a, w_alu, w_cmp, w_sh, w_in, w_out, w_hlt;
    logic       w_mem, w_wr, w_cond, w_take;
    logic [7:0] w_msel;
    logic       w_unused;

    assign w_op  = instr[15:14];
    assign w_sub = instr[13:11];
    assign w_cnd = instr[10:8];
    assign w_fn  = instr[7:4];

    assign w_ld  = (w_op == 2'b00);
    assign w_st  = (w_op == 2'b01);
    assign w_li  = (w_op == 2'b10) && (w_sub == 3'b000);
    assign w_b   = (w_op == 2'b10) && (w_sub == 3'b100);
    assign w_bc  = (w_op == 2'b10) && (w_sub == 3'b111) && !w_cnd[2];
    assign w_a   = (w_op == 2'b11);
    assign w_alu = w_a && (w_fn <= 4'd6);
    assign w_cmp = w_a && (w_fn == 4'd5);
    assign w_sh  = w_a && (w_fn[3:2] == 2'b10);
    assign w_in  = w_a && (w_fn == 4'd12);
    assign w_out = w_a && (w_fn == 4'd13);
    assign w_hlt = w_a && (w_fn == 4'd15);

    assign w_mem = w_ld | w_st | w_in | w_out;
    assign w_wr  = (w_alu & ~w_cmp) | w_sh | w_in | w_ld | w_li;

    // Decode ignores instr[3:0], upper IR bits and the carry flag.
    assign w_unused = ^{instr, flag_c};

    always_comb begin
        w_cond = 1'b0;
        unique case (w_cnd[1:0])
            2'b00: w_cond = flag_z;
            2'b01: w_cond = flag_s ^ flag_v;
            2'b10: w_cond = flag_z | (flag_s ^ flag_v);
            2'b11: w_cond = !flag_z;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_take = w_b | (w_bc & w_cond);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= P0;
            r_run   <= 1'b0;
            r_halt  <= 1'b0;
            r_stop  <= 1'b0;
            r_bt    <= 1'b0;
            r_wait  <= 2'd0;
        end else if (!r_run) begin
            r_phase <= P0;
            r_wait  <= 2'd0;
            r_bt    <= 1'b0;
            if (!r_halt) begin
                if (exec) begin
                    r_run  <= 1'b1;
                    r_stop <= 1'b0;
                end
`ifdef SINGLE_STEP_EN
                // A step is a run with the stop already requested.
                else if (step) begin
                    r_run  <= 1'b1;
                    r_stop <= 1'b1;
                end
`endif
            end
        end else begin
            if (exec) r_stop <= 1'b1;
            unique case (r_phase)
                P0: r_phase <= P1;
                P1: r_phase <= P2;
                P2: begin
                    r_phase <= P3;
                    r_bt    <= w_take;
                end
                P3: begin
                    if (w_mem && (r_wait != LP_WAIT)) begin
                        r_wait <= r_wait + 2'd1;
                    end else begin
                        r_wait  <= 2'd0;
                        r_phase <= P4;
                    end
                end
                P4: begin
                    r_phase <= P0;
                    r_bt    <= 1'b0;
                    if (w_hlt) begin
                        r_run  <= 1'b0;
                        r_halt <= 1'b1;
                        r_stop <= 1'b0;
                    end else if (r_stop || exec) begin
                        r_run  <= 1'b0;
                        r_stop <= 1'b0;
                    end
                end
                default: r_phase <= P0;
            endcase
        end
    end

    always_comb begin
        ir_e    = 1'b0;
        pc_e    = 1'b0;
        ar_e    = 1'b0;
        br_e    = 1'b0;
        dr_e    = 1'b0;
        mdr_e   = 1'b0;
        flags_e = 1'b0;
        genr_w  = 1'b0;
        mem_rd  = 1'b0;
        mem_w   = 1'b0;
        w_msel  = 8'd0;
        if (r_run) begin
            unique case (r_phase)
                P0: begin
                    mem_rd    = 1'b1;
                    ir_e      = 1'b1;
                    pc_e      = 1'b1;
                    w_msel[0] = 1'b1;
                end
                P1: begin
                    ar_e      = w_alu | w_out;
                    br_e      = w_alu | w_sh | w_ld | w_st;
                    w_msel[1] = w_sh | w_ld | w_st;
                end
                P2: begin
                    dr_e      = w_alu | w_sh | w_ld | w_st | w_b | w_bc;
                    flags_e   = w_alu | w_sh;
                    w_msel[2] = w_b | w_bc;
                end
                P3: begin
                    mem_rd    = w_ld | w_in;
                    mdr_e     = w_ld | w_in;
                    mem_w     = w_st;
                    w_msel[5] = w_st;
                    w_msel[6] = w_in;
                end
                P4: begin
                    genr_w    = w_wr;
                    pc_e      = (w_b | w_bc) & r_bt;
                    w_msel[3] = w_ld | w_in;
                    w_msel[4] = w_wr & ~w_ld;
                    w_msel[7] = w_li;
                end
                default: ;
            endcase
        end
    end

    assign phase        = r_phase;
    assign running      = r_run;
    assign halted       = r_halt;
    assign branch_taken = r_bt;
    assign alu_op       = (r_run && w_a) ? w_fn : 4'd0;
    assign m_sel        = MUX_W'(w_msel);

endmodule

// File: tb/tb_phase_sequencer_ctrl.sv
// Bench for phase_sequencer_ctrl: directed table, corner sequences,
// and random instruction streams against a class-level reference model.
module tb_phase_sequencer_ctrl;

    localparam int MW = 2;

    typedef struct packed {
        logic [2:0] ph;
        logic       run, hlt, ir, pc, ar, br, dr, mdr, fl, gw, mr, mw;
        logic [3:0] aop;
        logic [7:0] ms;
        logic       bt;
    } ov_t;

    typedef struct {
        logic [15:0] ins;
        logic [3:0]  flg;
        int          len;
        logic        gw4;
        logic        pc4;
        logic        bt3;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        exec;
    logic [15:0] instr;
    logic        flag_s, flag_z, flag_c, flag_v;
    logic [2:0]  phase;
    logic        running, halted;
    logic        ir_e, pc_e, ar_e, br_e, dr_e, mdr_e, flags_e;
    logic        genr_w, mem_rd, mem_w;
    logic [3:0]  alu_op;
    logic [7:0]  m_sel;
    logic        branch_taken;

    ov_t dut_v;
    ov_t exp_q[$];
    int  nvec = 0;
    int  nfail = 0;

    phase_sequencer_ctrl #(
        .INSTR_W (16),
        .MEM_WAIT(MW),
        .MUX_W   (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .exec        (exec),
`ifdef SINGLE_STEP_EN
        .step        (1'b0),
`endif
        .instr       (instr),
        .flag_s      (flag_s),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .phase       (phase),
        .running     (running),
        .halted      (halted),
        .ir_e        (ir_e),
        .pc_e        (pc_e),
        .ar_e        (ar_e),
        .br_e        (br_e),
        .dr_e        (dr_e),
        .mdr_e       (mdr_e),
        .flags_e     (flags_e),
        .genr_w      (genr_w),
        .mem_rd      (mem_rd),
        .mem_w       (mem_w),
        .alu_op      (alu_op),
        .m_sel       (m_sel),
        .branch_taken(branch_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb dut_v = {phase, running, halted, ir_e, pc_e, ar_e, br_e,
                         dr_e, mdr_e, flags_e, genr_w, mem_rd, mem_w,
                         alu_op, m_sel, branch_taken};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Expected per-cycle outputs for one instruction, from its class.
    task automatic build(input logic [15:0] ins, input logic [3:0] f);
        logic [1:0] op;
        logic [2:0] sub, cnd;
        logic [3:0] fn;
        logic s, z, v;
        logic ld, st, li, b, bc, alu, cmp, sh, inp, outp, tk, wr;
        int reps;
        ov_t e;
        op = ins[15:14]; sub = ins[13:11]; cnd = ins[10:8]; fn = ins[7:4];
        s = f[3]; z = f[2]; v = f[0];
        ld   = (op == 0);
        st   = (op == 1);
        li   = (op == 2) && (sub == 0);
        b    = (op == 2) && (sub == 4);
        bc   = (op == 2) && (sub == 7) && (cnd < 4);
        alu  = (op == 3) && (fn < 7);
        cmp  = (op == 3) && (fn == 5);
        sh   = (op == 3) && (fn >= 8) && (fn <= 11);
        inp  = (op == 3) && (fn == 12);
        outp = (op == 3) && (fn == 13);
        case (cnd)
            3'd0:    tk = z;
            3'd1:    tk = s ^ v;
            3'd2:    tk = z | (s ^ v);
            default: tk = !z;
        endcase
        tk = b | (bc & tk);
        wr = (alu && !cmp) || sh || inp || ld || li;
        exp_q.delete();
        for (int p = 0; p < 5; p++) begin
            reps = (p == 3 && (ld || st || inp || outp)) ? 1 + MW : 1;
            for (int r = 0; r < reps; r++) begin
                e = '0;
                e.ph = 3'(p);
                e.run = 1'b1;
                e.aop = (op == 3) ? fn : 4'd0;
                if (p == 0) begin
                    e.mr = 1; e.ir = 1; e.pc = 1; e.ms[0] = 1;
                end else if (p == 1) begin
                    if (alu) begin e.ar = 1; e.br = 1; end
                    if (sh || ld || st) begin e.br = 1; e.ms[1] = 1; end
                    if (outp) e.ar = 1;
                end else if (p == 2) begin
                    e.dr = alu || sh || ld || st || b || bc;
                    e.fl = alu || sh;
                    e.ms[2] = b || bc;
                end else if (p == 3) begin
                    if (ld || inp) begin e.mr = 1; e.mdr = 1; end
                    if (inp) e.ms[6] = 1;
                    if (st) begin e.mw = 1; e.ms[5] = 1; end
                    e.bt = tk;
                end else begin
                    e.gw = wr;
                    e.ms[4] = wr && !ld;
                    e.ms[3] = ld || inp;
                    e.ms[7] = li;
                    e.pc = tk;
                    e.bt = tk;
                end
                exp_q.push_back(e);
            end
        end
    endtask

    // From idle: start one instruction, request stop at stop_ph.
    task automatic run_one(input logic [15:0] ins, input logic [3:0] f,
                           input int stop_ph, output int len,
                           output logic gw4, output logic pc4,
                           output logic bt3);
        bit asked;
        asked = 0;
        len = 0; gw4 = 0; pc4 = 0; bt3 = 0;
        instr = ins;
        {flag_s, flag_z, flag_c, flag_v} = f;
        exec = 1'b1;
        @(negedge clk);
        exec = 1'b0;
        for (int c = 0; c < 20 && running; c++) begin
            len++;
            if (phase == 3'd4) begin gw4 = genr_w; pc4 = pc_e; end
            if (phase == 3'd3) bt3 = branch_taken;
            if (!asked && phase == 3'(stop_ph)) begin
                exec = 1'b1; asked = 1;
            end else begin
                exec = 1'b0;
            end
            @(negedge clk);
        end
        exec = 1'b0;
        chk("run_timeout", 32'(running), 32'd0);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        if ($urandom_range(0, 1) == 1)
            r[13:11] = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b100;
        if (r[15:14] == 2'b11 && r[7:4] == 4'hF) r[7:4] = 4'h0;
        return r;
    endfunction

    vec_t tbl[17];
    ov_t  cur[$];
    ov_t  hv;
    int   len;
    logic gw4, pc4, bt3;
    logic [15:0] ri;
    logic [3:0]  rf;
    int   n;

    initial begin
        tbl[0]  = '{16'hC000, 4'b0000, 5, 1, 0, 0};
        tbl[1]  = '{16'hC050, 4'b0000, 5, 0, 0, 0};
        tbl[2]  = '{16'h0000, 4'b0000, 7, 1, 0, 0};
        tbl[3]  = '{16'h4000, 4'b0000, 7, 0, 0, 0};
        tbl[4]  = '{16'hC0C0, 4'b0000, 7, 1, 0, 0};
        tbl[5]  = '{16'hC0D0, 4'b0000, 7, 0, 0, 0};
        tbl[6]  = '{16'h8000, 4'b0000, 5, 1, 0, 0};
        tbl[7]  = '{16'hA000, 4'b0000, 5, 0, 1, 1};
        tbl[8]  = '{16'hB800, 4'b0100, 5, 0, 1, 1};
        tbl[9]  = '{16'hB800, 4'b0000, 5, 0, 0, 0};
        tbl[10] = '{16'hB900, 4'b1000, 5, 0, 1, 1};
        tbl[11] = '{16'hB900, 4'b1001, 5, 0, 0, 0};
        tbl[12] = '{16'hBA00, 4'b0001, 5, 0, 1, 1};
        tbl[13] = '{16'hBB00, 4'b0100, 5, 0, 0, 0};
        tbl[14] = '{16'hC070, 4'b0000, 5, 0, 0, 0};
        tbl[15] = '{16'hBC00, 4'b0100, 5, 0, 0, 0};
        tbl[16] = '{16'hC080, 4'b0000, 5, 1, 0, 0};

        rst_n = 1'b0; exec = 1'b0; instr = 16'h0;
        {flag_s, flag_z, flag_c, flag_v} = 4'b0;
        @(negedge clk);
        chk("reset_state", 32'(dut_v), 32'd0);
        exec = 1'b1;
        @(negedge clk);
        chk("exec_in_reset", 32'(dut_v), 32'd0);
        exec = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 32'(dut_v), 32'd0);

        for (int i = 0; i < 17; i++) begin
            run_one(tbl[i].ins, tbl[i].flg, 1, len, gw4, pc4, bt3);
            chk($sformatf("len_%0d", i), 32'(len), 32'(tbl[i].len));
            chk($sformatf("genr_w_p4_%0d", i), 32'(gw4), 32'(tbl[i].gw4));
            chk($sformatf("pc_e_p4_%0d", i), 32'(pc4), 32'(tbl[i].pc4));
            chk($sformatf("bt_p3_%0d", i), 32'(bt3), 32'(tbl[i].bt3));
            chk($sformatf("idle_%0d", i), 32'(dut_v), 32'd0);
        end

        // Stop request during P2 lets the ADD finish.
        run_one(16'hC000, 4'b0000, 2, len, gw4, pc4, bt3);
        chk("stop_p2_len", 32'(len), 32'd5);
        chk("stop_p2_gw", 32'(gw4), 32'd1);
        chk("stop_p2_idle", 32'(dut_v), 32'd0);

        // HLT is sticky and ignores later exec.
        run_one(16'hC0F0, 4'b0000, 9, len, gw4, pc4, bt3);
        hv = '0;
        hv.hlt = 1'b1;
        chk("hlt_len", 32'(len), 32'd5);
        chk("hlt_state", 32'(dut_v), 32'(hv));
        exec = 1'b1;
        @(negedge clk);
        exec = 1'b0;
        @(negedge clk);
        chk("hlt_exec_ignored", 32'(dut_v), 32'(hv));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("hlt_cleared_by_reset", 32'(dut_v), 32'd0);

        // Reset mid-P3 of ST drops strobes at once.
        instr = 16'h4000;
        exec = 1'b1;
        @(negedge clk);
        exec = 1'b0;
        n = 0;
        while (phase != 3'd3 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("st_p3_reached", 32'(phase), 32'd3);
        chk("st_p3_mem_w", 32'(mem_w), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("st_async_reset", 32'(dut_v), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("st_reset_idle", 32'(dut_v), 32'd0);

        // Random back-to-back stream against the class model.
        ri = rand_instr();
        rf = 4'($urandom);
        instr = ri;
        {flag_s, flag_z, flag_c, flag_v} = rf;
        build(ri, rf);
        exec = 1'b1;
        @(negedge clk);
        exec = 1'b0;
        for (int k = 0; k < 40; k++) begin
            cur = exp_q;
            for (int i = 0; i < cur.size(); i++) begin
                chk($sformatf("rand_%0d_%h_c%0d", k, instr, i),
                    32'(dut_v), 32'(cur[i]));
                exec = (k == 39 && i == 1);
                if (i == cur.size() - 1 && k < 39) begin
                    ri = rand_instr();
                    rf = 4'($urandom);
                    instr = ri;
                    {flag_s, flag_z, flag_c, flag_v} = rf;
                    build(ri, rf);
                end
                @(negedge clk);
            end
        end
        exec = 1'b0;
        chk("rand_final_idle", 32'(dut_v), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
